// File: rtl/regwrite_arbiter.sv
// Round-robin arbiter sharing one register-file write port between requesters A and B.
// Optional idle-grant timeout enabled by defining REGWRITE_ARBITER_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no owner; at least one cycle between grants
// GRANT_A | requester A owns the write port
// GRANT_B | requester B owns the write port
module regwrite_arbiter #(
  parameter int width          = 16,
  parameter int num_reg        = 4,
  parameter int timeout_cycles = 255,
  parameter int addr_width     = $clog2(num_reg)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic [addr_width-1:0] a_addr,
  input  logic [width-1:0]      a_data,
  input  logic                  a_enable,
  input  logic                  a_done,
  output logic                  a_grant,
  input  logic                  b_req,
  input  logic [addr_width-1:0] b_addr,
  input  logic [width-1:0]      b_data,
  input  logic                  b_enable,
  input  logic                  b_done,
  output logic                  b_grant,
  output logic [addr_width-1:0] reg_addr,
  output logic [width-1:0]      reg_data,
  output logic                  reg_we,
  output logic [7:0]            drop_count,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       ptr_b, ptr_b_nxt;
  logic       timeout_hit;
  logic       wr_a, wr_b;
  logic       drop_a, drop_b;
  logic [8:0] drop_sum;
  logic [7:0] drop_nxt;

  assign wr_a   = (state == GRANT_A) && a_enable;
  assign wr_b   = (state == GRANT_B) && b_enable;
  assign drop_a = a_enable && (state != GRANT_A);
  assign drop_b = b_enable && (state != GRANT_B);

  // Both requesters can strobe in IDLE, so up to two drops per cycle.
  assign drop_sum = {1'b0, drop_count} + 9'(drop_a) + 9'(drop_b);
  assign drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_comb begin
    state_nxt = state;
    ptr_b_nxt = ptr_b;
    case (state)
      IDLE: begin
        if (a_req && b_req)
          state_nxt = ptr_b ? GRANT_B : GRANT_A;
        else if (a_req)
          state_nxt = GRANT_A;
        else if (b_req)
          state_nxt = GRANT_B;
      end
      GRANT_A: begin
        if (a_done || !a_req || timeout_hit) begin
          state_nxt = IDLE;
          ptr_b_nxt = 1'b1;
        end
      end
      GRANT_B: begin
        if (b_done || !b_req || timeout_hit) begin
          state_nxt = IDLE;
          ptr_b_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr_b      <= 1'b0;
      a_grant    <= 1'b0;
      b_grant    <= 1'b0;
      reg_we     <= 1'b0;
      reg_addr   <= '0;
      reg_data   <= '0;
      drop_count <= 8'd0;
    end else begin
      state      <= state_nxt;
      ptr_b      <= ptr_b_nxt;
      a_grant    <= (state_nxt == GRANT_A);
      b_grant    <= (state_nxt == GRANT_B);
      reg_we     <= wr_a || wr_b;
      drop_count <= drop_nxt;
      if (wr_a) begin
        reg_addr <= a_addr;
        reg_data <= a_data;
      end else if (wr_b) begin
        reg_addr <= b_addr;
        reg_data <= b_data;
      end
    end
  end

`ifdef REGWRITE_ARBITER_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        granted_wr;

  assign granted_wr  = wr_a || wr_b;
  // A granted write in the limit cycle keeps the grant alive.
  assign timeout_hit = (state != IDLE) && !granted_wr &&
                       (idle_cnt >= 16'(timeout_cycles));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= 16'd0;
      timeout  <= 1'b0;
    end else begin
      timeout <= timeout_hit;
      if (state == IDLE || granted_wr)
        idle_cnt <= 16'd0;
      else if (idle_cnt != 16'hFFFF)
        idle_cnt <= idle_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter; timeout scenario runs only when
// REGWRITE_ARBITER_TIMEOUT_EN is defined.
module tb_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_enable, a_done, a_grant;
  logic [1:0]  a_addr;
  logic [15:0] a_data;
  logic        b_req, b_enable, b_done, b_grant;
  logic [1:0]  b_addr;
  logic [15:0] b_data;
  logic [1:0]  reg_addr;
  logic [15:0] reg_data;
  logic        reg_we;
  logic [7:0]  drop_count;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  regwrite_arbiter #(
    .width(16),
    .num_reg(4),
    .timeout_cycles(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a_req(a_req),
    .a_addr(a_addr),
    .a_data(a_data),
    .a_enable(a_enable),
    .a_done(a_done),
    .a_grant(a_grant),
    .b_req(b_req),
    .b_addr(b_addr),
    .b_data(b_data),
    .b_enable(b_enable),
    .b_done(b_done),
    .b_grant(b_grant),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .reg_we(reg_we),
    .drop_count(drop_count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req = 0; a_enable = 0; a_done = 0; a_addr = 0; a_data = 0;
    b_req = 0; b_enable = 0; b_done = 0; b_addr = 0; b_data = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_grant"}, 32'(a_grant), 0);
    check({tag, "_b_grant"}, 32'(b_grant), 0);
    check({tag, "_reg_we"}, 32'(reg_we), 0);
    check({tag, "_reg_addr"}, 32'(reg_addr), 0);
    check({tag, "_reg_data"}, 32'(reg_data), 0);
    check({tag, "_drop"}, 32'(drop_count), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    step();
  endtask

  // Sends n back-to-back words from the granted requester, then a done pulse.
  task automatic do_words(input bit sel_b, input int n, input logic [1:0] addr0,
                          input logic [15:0] data0);
    logic [1:0]  ea;
    logic [15:0] ed;
    for (int i = 0; i < n; i++) begin
      ea = addr0 + 2'(i);
      ed = 16'(data0 * 16'(i + 1));
      if (sel_b) begin b_enable = 1; b_addr = ea; b_data = ed; end
      else       begin a_enable = 1; a_addr = ea; a_data = ed; end
      step();
      a_enable = 0; b_enable = 0;
      check("word_we", 32'(reg_we), 1);
      check("word_addr", 32'(reg_addr), 32'(ea));
      check("word_data", 32'(reg_data), 32'(ed));
      check("one_hot_grant", 32'(a_grant & b_grant), 0);
    end
    if (sel_b) b_done = 1; else a_done = 1;
    step();
    check("release_grant", 32'(sel_b ? b_grant : a_grant), 0);
    check("release_we", 32'(reg_we), 0);
    if (sel_b) begin b_done = 0; b_req = 0; end
    else       begin a_done = 0; a_req = 0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    step();
    step();
    check_reset_outputs("rst_hold");
    @(negedge clk) rst = 0;
    step();

    // Single A transfer, four words
    a_req = 1;
    step();
    check("t1_a_grant", 32'(a_grant), 1);
    check("t1_b_grant", 32'(b_grant), 0);
    do_words(0, 4, 2'd0, 16'h1111);
    step();

    // Simultaneous requests, pointer at A after reset
    do_reset();
    a_req = 1; b_req = 1;
    step();
    check("rr1_a_first", 32'(a_grant), 1);
    check("rr1_b_wait", 32'(b_grant), 0);
    do_words(0, 2, 2'd1, 16'h0A0A);
    step();
    check("rr1_b_second", 32'(b_grant), 1);
    do_words(1, 2, 2'd2, 16'h0B0B);
    step();

    // Lone A moves the pointer to B, then simultaneous requests
    a_req = 1;
    step();
    do_words(0, 1, 2'd3, 16'h0C0C);
    step();
    a_req = 1; b_req = 1;
    step();
    check("rr2_b_first", 32'(b_grant), 1);
    check("rr2_a_wait", 32'(a_grant), 0);
    do_words(1, 2, 2'd0, 16'h0D0D);
    step();
    check("rr2_a_second", 32'(a_grant), 1);
    do_words(0, 2, 2'd1, 16'h0E0E);
    step();

    // B strobes during an A grant are dropped
    do_reset();
    a_req = 1;
    step();
    for (int j = 0; j < 3; j++) begin
      b_enable = 1; b_addr = 2'd3; b_data = 16'hDEAD;
      step();
      b_enable = 0;
      check("drop_no_we", 32'(reg_we), 0);
      step();
    end
    check("drop_three", 32'(drop_count), 3);
    a_enable = 1; a_addr = 2'd1; a_data = 16'h5A5A;
    b_enable = 1; b_addr = 2'd2; b_data = 16'hBEEF;
    step();
    a_enable = 0; b_enable = 0;
    check("both_we", 32'(reg_we), 1);
    check("both_addr", 32'(reg_addr), 1);
    check("both_data", 32'(reg_data), 32'h5A5A);
    check("both_drop", 32'(drop_count), 4);
    a_done = 1;
    step();
    check("drop_release", 32'(a_grant), 0);
    a_done = 0; a_req = 0;
    step();

    // 300 stray strobes in IDLE saturate the drop counter
    b_enable = 1;
    for (int j = 0; j < 250; j++) step();
    check("sat_254", 32'(drop_count), 254);
    a_enable = 1;
    step();
    a_enable = 0;
    check("sat_double", 32'(drop_count), 255);
    for (int j = 0; j < 48; j++) step();
    b_enable = 0;
    check("sat_255", 32'(drop_count), 255);
    check("sat_no_we", 32'(reg_we), 0);
    step();

    // Done coincident with the last enable
    a_req = 1;
    step();
    check("last_grant", 32'(a_grant), 1);
    a_enable = 1; a_addr = 2'd0; a_data = 16'h1234;
    step();
    check("last_w1_data", 32'(reg_data), 32'h1234);
    a_addr = 2'd2; a_data = 16'hABCD; a_done = 1;
    step();
    a_enable = 0; a_done = 0; a_req = 0;
    check("last_we", 32'(reg_we), 1);
    check("last_addr", 32'(reg_addr), 2);
    check("last_data", 32'(reg_data), 32'hABCD);
    check("last_grant_low", 32'(a_grant), 0);
    step();

`ifdef REGWRITE_ARBITER_TIMEOUT_EN
    do_reset();
    a_req = 1;
    step();
    check("to_grant", 32'(a_grant), 1);
    b_req = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("to_hold_grant", 32'(a_grant), 1);
      check("to_no_pulse", 32'(timeout), 0);
    end
    step();
    check("to_pulse", 32'(timeout), 1);
    check("to_revoked", 32'(a_grant), 0);
    a_enable = 1;
    step();
    a_enable = 0;
    check("to_pulse_end", 32'(timeout), 0);
    check("to_b_grant", 32'(b_grant), 1);
    check("to_a_drop", 32'(drop_count), 1);
    a_req = 0; b_req = 0;
    step();
    step();
`endif

    // Asynchronous reset mid-transfer with a write on the port
    a_req = 1;
    step();
    a_enable = 1; a_addr = 2'd2; a_data = 16'h7777;
    step();
    a_enable = 0;
    check("pre_rst_we", 32'(reg_we), 1);
    #2 rst = 1;
    #1;
    check_reset_outputs("async_rst");
    clear_inputs();
    @(negedge clk) rst = 0;
    step();
    a_req = 1;
    step();
    check("post_rst_grant", 32'(a_grant), 1);
    do_words(0, 1, 2'd3, 16'h0F0F);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
